// File: rtl/clock_div_if.sv
// clock_div_if: divide value in, divided clock out.
// master drives div_num, slave (divider) drives clk_out.
interface clock_div_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] div_num;
  logic             clk_out;

  modport master (
    output div_num,
    input  clk_out
  );

  modport slave (
    input  div_num,
    output clk_out
  );
endinterface

// File: rtl/clock_div.sv
// clock_div: toggles clk_out every div_num+1 clk_in edges.
// Ports: clk_in, reset (async, active-low), bus.slave (div_num, clk_out).
module clock_div #(
  parameter int WIDTH = 32
) (
  input  logic        clk_in,
  input  logic        reset,
  clock_div_if.slave  bus
);
  logic [WIDTH-1:0] count;
  logic             clk_q;
  logic             hit;

  // >= so a lowered div_num restarts at once instead of wrapping
  assign hit = (count >= bus.div_num);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count <= '0;
      clk_q <= 1'b0;
    end else if (hit) begin
      count <= '0;
      clk_q <= ~clk_q;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bus.clk_out = clk_q;
endmodule

// File: tb/tb_clock_div.sv
// tb_clock_div: vector table plus corner sequences.
// Scoreboard queue holds expected clk_out per edge.
module tb_clock_div;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic reset8;

  clock_div_if #(.WIDTH(32)) bus ();
  clock_div_if #(.WIDTH(8))  bus8 ();

  clock_div #(.WIDTH(32)) dut (
    .clk_in (clk),
    .reset  (reset),
    .bus    (bus)
  );

  clock_div #(.WIDTH(8)) dut8 (
    .clk_in (clk),
    .reset  (reset8),
    .bus    (bus8)
  );

  typedef struct {
    logic        rst;
    logic [31:0] div;
    logic        exp;
    string       tag;
  } vec_t;

  vec_t tbl[$];
  logic exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(
    input logic        r,
    input logic [31:0] d,
    input logic        e,
    input string       t
  );
    vec_t v;
    v.rst = r;
    v.div = d;
    v.exp = e;
    v.tag = t;
    tbl.push_back(v);
  endfunction

  task automatic check(
    input string t,
    input logic  act,
    input logic  exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: clk_out=%0b expected %0b at %0t",
               t, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    logic e;
    @(negedge clk);
    reset = v.rst;
    bus.div_num = v.div;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1'bx, v.exp);
    end else begin
      e = exp_q.pop_front();
      check(v.tag, bus.clk_out, e);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time expired, no finish");
    $fatal(1);
  end

  initial begin
    vec_t h;
    logic e8;
    reset  = 1'b0;
    reset8 = 1'b0;
    bus.div_num  = 32'd3;
    bus8.div_num = 8'd255;

    #1;
    check("reset_t0", bus.clk_out, 1'b0);

    for (int i = 0; i < 10; i++)
      add(1'b0, 32'd3, 1'b0, "reset_hold");
    for (int e = 1; e <= 12; e++)
      add(1'b1, 32'd3,
          ((e >= 4 && e < 8) || e >= 12), "nominal");
    add(1'b0, 32'd0, 1'b0, "rst_min");
    for (int e = 1; e <= 4; e++)
      add(1'b1, 32'd0, (e % 2 == 1), "min_div");
    add(1'b0, 32'd9, 1'b0, "rst_dec");
    for (int e = 1; e <= 6; e++)
      add(1'b1, 32'd9, 1'b0, "dec_pre");
    for (int e = 7; e <= 13; e++)
      add(1'b1, 32'd2, (e < 10 || e >= 13), "dec_post");
    add(1'b0, 32'd4, 1'b0, "rst_mid");
    for (int e = 1; e <= 7; e++)
      add(1'b1, 32'd4, (e >= 5), "mid_pre");

    foreach (tbl[i]) apply(tbl[i]);

    // async clear while clk_out is high, well before the next edge
    @(negedge clk);
    check("mid_high", bus.clk_out, 1'b1);
    reset = 1'b0;
    #1;
    check("async_reset", bus.clk_out, 1'b0);

    for (int i = 0; i < 3; i++) begin
      h.rst = 1'b0; h.div = 32'd4;
      h.exp = 1'b0; h.tag = "mid_hold";
      apply(h);
    end
    for (int e = 1; e <= 11; e++) begin
      h.rst = 1'b1; h.div = 32'd4;
      h.exp = (e >= 5 && e < 10);
      h.tag = "mid_post";
      apply(h);
    end

    check("w8_reset", bus8.clk_out, 1'b0);
    @(negedge clk);
    reset8 = 1'b1;
    for (int e = 1; e <= 600; e++) begin
      exp_q.push_back(e >= 256 && e < 512);
      @(posedge clk);
      #1;
      e8 = exp_q.pop_front();
      check("w8_max", bus8.clk_out, e8);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
